// File: rtl/core_io_pkg.sv
//------------------------------------------------------------------------------
// Module : core_io_pkg
// Brief  : Shared state encoding and width helpers for the byte sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package core_io_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    EXEC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int bytes_per_word(input int xlen);
    return xlen / BYTE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_byte_sequencer_byte_serializer.sv
//------------------------------------------------------------------------------
// Module : byte_serializer
// Brief  : Captures a datapath result and streams it out LSB byte first.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module byte_serializer
  import core_io_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DRAIN_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [XLEN-1:0]   i_result,
  input  logic              i_we,
  input  logic              i_ready,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_we,
  output logic              o_done
);

  localparam int NB    = bytes_per_word(XLEN);
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NB - 1);

  logic [XLEN-1:0]  r_result;
  logic [IDX_W-1:0] r_oidx;
  logic             r_valid;
  logic             r_we;
  logic             w_fire;

  assign w_fire  = r_valid && i_ready;
  assign o_done  = w_fire && (r_oidx == c_LAST);
  assign o_data  = r_result[BYTE_W*r_oidx +: BYTE_W];
  assign o_valid = r_valid;
  assign o_we    = r_we;

  // A load always restarts the stream at byte 0, even if the previous one
  // was abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_oidx   <= '0;
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
    end else if (i_load) begin
      r_result <= i_result;
      r_we     <= i_we;
      r_oidx   <= '0;
      r_valid  <= (DRAIN_EN != 0);
    end else if (w_fire) begin
      if (r_oidx == c_LAST) begin
        r_oidx  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_oidx <= r_oidx + IDX_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_byte_sequencer.sv
//------------------------------------------------------------------------------
// Module : core_byte_sequencer
// Brief  : Assembles instructions from pin bytes, steps the datapath once per
//          instruction and returns the captured ALU result byte-wise.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module core_byte_sequencer
  import core_io_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DRAIN_EN = 1,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [XLEN-1:0]     instr,
  output logic                core_step,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                write_enable,
  output logic [BYTE_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_we,
  output logic [RETIRE_W-1:0] retired,
  output logic                busy
);

  localparam int NB    = bytes_per_word(XLEN);
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NB - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [XLEN-1:0]     r_instr;
  logic [RETIRE_W-1:0] r_retired;
  logic                w_drain_done;

  assign in_ready  = (r_state == LOAD);
  assign core_step = (r_state == EXEC);
  assign busy      = (r_state != LOAD);
  assign instr     = r_instr;
  assign retired   = r_retired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= LOAD;
      r_idx     <= '0;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid) begin
            r_instr[BYTE_W*r_idx +: BYTE_W] <= in_data;
            if (r_idx == c_LAST) begin
              r_idx   <= '0;
              r_state <= EXEC;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        EXEC: begin
          r_retired <= r_retired + RETIRE_W'(1);
          r_state   <= (DRAIN_EN != 0) ? DRAIN : LOAD;
        end
        DRAIN: begin
          if (w_drain_done) r_state <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  // The result is captured on the step cycle itself, while the datapath
  // is still presenting it combinationally.
  byte_serializer #(
    .XLEN     (XLEN),
    .DRAIN_EN (DRAIN_EN)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (core_step),
    .i_result (alu_result),
    .i_we     (write_enable),
    .i_ready  (out_ready),
    .o_data   (out_data),
    .o_valid  (out_valid),
    .o_we     (out_we),
    .o_done   (w_drain_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_core_byte_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_core_byte_sequencer
// Brief  : Self-checking bench: table vectors, corner sequences, random runs.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_core_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst, sel, in_valid, we, out_ready;
  logic [7:0]  in_data;
  logic [31:0] alu;

  logic        a_in_ready, a_core_step, a_out_valid, a_out_we, a_busy;
  logic [31:0] a_instr;
  logic [7:0]  a_out_data;
  logic [15:0] a_retired;
  logic        b_in_ready, b_core_step, b_out_valid, b_out_we, b_busy;
  logic [31:0] b_instr;
  logic [7:0]  b_out_data;
  logic [3:0]  b_retired;

  logic        w_in_ready, w_core_step, w_out_valid, w_out_we, w_busy;
  logic [31:0] w_instr;
  logic [7:0]  w_out_data;
  logic [15:0] w_retired;

  int checks = 0, errors = 0;
  int a_steps = 0, a_exp_steps = 0, b_ov_cnt = 0;
  int a_ret_model = 0, b_ret_model = 0;

  always #5 clk = ~clk;

  core_byte_sequencer #(.XLEN(32), .DRAIN_EN(1), .RETIRE_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid & ~sel),
    .in_ready(a_in_ready), .instr(a_instr), .core_step(a_core_step),
    .alu_result(alu), .write_enable(we), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_we(a_out_we),
    .retired(a_retired), .busy(a_busy));

  core_byte_sequencer #(.XLEN(32), .DRAIN_EN(0), .RETIRE_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid & sel),
    .in_ready(b_in_ready), .instr(b_instr), .core_step(b_core_step),
    .alu_result(alu), .write_enable(we), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_we(b_out_we),
    .retired(b_retired), .busy(b_busy));

  assign w_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign w_core_step = sel ? b_core_step : a_core_step;
  assign w_out_valid = sel ? b_out_valid : a_out_valid;
  assign w_out_we    = sel ? b_out_we    : a_out_we;
  assign w_busy      = sel ? b_busy      : a_busy;
  assign w_instr     = sel ? b_instr     : a_instr;
  assign w_out_data  = sel ? b_out_data  : a_out_data;
  assign w_retired   = sel ? {12'd0, b_retired} : a_retired;

  always @(negedge clk) begin
    if (a_core_step) a_steps++;
    if (b_out_valid) b_ov_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", w_in_ready, 1);
    check("rst_busy", w_busy, 0);
    check("rst_out_valid", w_out_valid, 0);
    check("rst_core_step", w_core_step, 0);
    check("rst_retired", w_retired, 0);
    check("rst_instr", w_instr, 0);
    check("rst_out_we", w_out_we, 0);
    rst = 1'b0;
    a_ret_model = 0; b_ret_model = 0;
  endtask

  // Returns at the negedge of the step cycle (one cycle after the last byte).
  task automatic load_word(input logic [7:0] b [4], input int gap, input logic hold,
                           input logic [31:0] exp_instr);
    for (int i = 0; i < 4; i++) begin
      bit done = 0;
      int n = 0;
      repeat (gap) begin
        @(negedge clk); in_valid = 1'b0;
        check("no_step_gap", w_core_step, 0);
      end
      while (!done) begin
        @(negedge clk); in_valid = 1'b1; in_data = b[i];
        check("no_step_load", w_core_step, 0);
        if (w_in_ready) done = 1;
        else if (++n > 20) begin check("load_timeout", 0, 1); done = 1; end
      end
    end
    @(negedge clk);
    in_valid = hold; in_data = 8'hEE;
    check("step_n1", w_core_step, 1);
    check("instr", w_instr, exp_instr);
    check("ready_exec", w_in_ready, 0);
    check("busy_exec", w_busy, 1);
    if (!sel) a_exp_steps++;
  endtask

  task automatic drain(input logic [31:0] exp_out, input logic we_exp, input int stall_at,
                       input int stall_len, input logic hold, input logic [31:0] exp_instr);
    int k = 0, stalled = 0, cyc = 0;
    @(negedge clk);
    check("out_valid_n2", w_out_valid, 1);
    check("out_we", w_out_we, we_exp);
    while (k < 4 && cyc < 64) begin
      if (hold) begin
        check("ready_drain", w_in_ready, 0);
        check("instr_hold", w_instr, exp_instr);
      end
      if (k == stall_at && stalled < stall_len) begin
        out_ready = 1'b0; stalled++;
        check("stall_valid", w_out_valid, 1);
        check("stall_data", w_out_data, exp_out[8*k +: 8]);
      end else begin
        out_ready = 1'b1;
        if (w_out_valid) begin
          check("out_byte", w_out_data, exp_out[8*k +: 8]);
          k++;
        end
      end
      @(negedge clk); cyc++;
    end
    if (k < 4) check("drain_timeout", k, 4);
    in_valid = 1'b0; out_ready = 1'b1;
    check("ready_after", w_in_ready, 1);
    check("valid_after", w_out_valid, 0);
  endtask

  task automatic run_txn(input logic [7:0] b [4], input logic [31:0] alu_v, input logic we_v,
                         input int gap, input int stall_at, input int stall_len, input logic hold);
    logic [31:0] exp_instr;
    exp_instr = 32'(b[0]) + (32'(b[1]) << 8) + (32'(b[2]) << 16) + (32'(b[3]) << 24);
    sel = 1'b0; alu = alu_v; we = we_v;
    load_word(b, gap, hold, exp_instr);
    drain(alu_v, we_v, stall_at, stall_len, hold, exp_instr);
    a_ret_model = (a_ret_model + 1) % 65536;
    check("retired", w_retired, a_ret_model);
    check("steps_once", a_steps, a_exp_steps);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] alu;
    logic        we;
    int          gap, stall_at, stall_len;
    logic        hold;
    logic [31:0] exp_instr;
    logic [31:0] exp_out;  // byte k of the stream is exp_out[8k+:8]
  } vec_t;

  vec_t        tbl [4];
  logic [7:0]  bb  [4];
  logic [31:0] e_instr;

  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    we = 1'b0; alu = 32'h0; out_ready = 1'b1;

    tbl[0] = '{8'h93, 8'h00, 8'h50, 8'h00, 32'h00000005, 1'b0, 0, 0, 0, 1'b0,
               32'h00500093, 32'h00000005};
    tbl[1] = '{8'h13, 8'h01, 8'hA0, 8'hFF, 32'hDEADBEEF, 1'b1, 2, 1, 3, 1'b0,
               32'hFFA00113, 32'hDEADBEEF};
    tbl[2] = '{8'h23, 8'h20, 8'hB5, 8'h00, 32'h01020304, 1'b1, 0, 2, 1, 1'b1,
               32'h00B52023, 32'h01020304};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'h80000001, 1'b0, 1, 0, 2, 1'b1,
               32'hFFFFFFFF, 32'h80000001};

    do_reset();

    for (int t = 0; t < 4; t++) begin
      bb[0] = tbl[t].b0; bb[1] = tbl[t].b1; bb[2] = tbl[t].b2; bb[3] = tbl[t].b3;
      sel = 1'b0; alu = tbl[t].alu; we = tbl[t].we;
      load_word(bb, tbl[t].gap, tbl[t].hold, tbl[t].exp_instr);
      drain(tbl[t].exp_out, tbl[t].we, tbl[t].stall_at, tbl[t].stall_len,
            tbl[t].hold, tbl[t].exp_instr);
      a_ret_model++;
      check("tbl_retired", w_retired, a_ret_model);
      check("tbl_steps", a_steps, a_exp_steps);
    end

    // Reset with a partial instruction loaded: idx must restart at 0.
    @(negedge clk); in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk); in_data = 8'h22;
    @(negedge clk); in_valid = 1'b0;
    do_reset();
    bb[0] = 8'h93; bb[1] = 8'h00; bb[2] = 8'h50; bb[3] = 8'h00;
    run_txn(bb, 32'h00000005, 1'b0, 0, 0, 0, 1'b0);

    // Reset in the middle of a stalled drain.
    bb[0] = 8'hB3; bb[1] = 8'h81; bb[2] = 8'h20; bb[3] = 8'h00;
    e_instr = 32'h002081B3;
    sel = 1'b0; alu = 32'hCAFEF00D; we = 1'b1;
    load_word(bb, 0, 1'b0, e_instr);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("mid_drain_valid", w_out_valid, 1);
    do_reset();
    bb[0] = 8'h13; bb[1] = 8'h05; bb[2] = 8'h70; bb[3] = 8'h00;
    run_txn(bb, 32'h00000007, 1'b0, 1, 0, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) bb[i] = 8'($urandom);
      run_txn(bb, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Non-draining variant with a 4-bit retired counter.
    @(negedge clk);
    sel = 1'b1; alu = 32'h12345678; we = 1'b1;
    bb[0] = 8'h93; bb[1] = 8'h00; bb[2] = 8'h50; bb[3] = 8'h00;
    load_word(bb, 0, 1'b0, 32'h00500093);
    @(negedge clk);
    check("b_ready_n2", w_in_ready, 1);
    check("b_out_valid", w_out_valid, 0);
    check("b_out_we", w_out_we, 1);
    check("b_busy", w_busy, 0);
    b_ret_model = 1;
    we = 1'b0;
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 4; i++) bb[i] = 8'($urandom);
      e_instr = 32'(bb[0]) + (32'(bb[1]) << 8) + (32'(bb[2]) << 16) + (32'(bb[3]) << 24);
      load_word(bb, $urandom_range(0, 1), 1'b0, e_instr);
      b_ret_model = (b_ret_model + 1) % 16;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b_retired_wrap", w_retired, b_ret_model);
    check("b_retired_is_1", w_retired, 1);
    check("b_never_valid", b_ov_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_byte_sequencer.md
Name: core_byte_sequencer

Overview:
Sequencer between the 8-bit TinyTapeout pins and the 32-bit single_cycle_datapath.
- Assembles each instruction from four input bytes.
- Issues exactly one datapath clock-enable pulse per instruction.
- Captures alu_result and write_enable in that cycle.
- Streams the captured result back out one byte per handshake.
- Instantiated in the top-level wrapper between the pins and the datapath instance.

Parameters:
XLEN, 32, datapath word width; must be a multiple of 8.
DRAIN_EN, 1, 1 = stream result bytes after each step; 0 = return straight to LOAD.
RETIRE_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_data  input  8  instruction byte, little-endian order
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted when in_valid && in_ready
instr  output  XLEN  assembled instruction to datapath
core_step  output  1  one-cycle datapath enable (PC/regfile update)
alu_result  input  XLEN  datapath ALU result, combinational during core_step
write_enable  input  1  datapath store strobe, combinational during core_step
out_data  output  8  result byte, LSB first
out_valid  output  1  out_data valid
out_ready  input  1  byte consumed when out_valid && out_ready
out_we  output  1  captured write_enable of the last step, held with result bytes
retired  output  RETIRE_W  count of core_step pulses
busy  output  1  high in EXEC or DRAIN

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: state=LOAD, byte index=0, instr=0, result register=0, out_we=0, retired=0, core_step=0, out_valid=0, in_ready=1, busy=0. Reset in any state aborts the operation:
  - any partial instruction is discarded;
  - no core_step is issued in the reset cycle.
- State LOAD:
  - in_ready=1.
  - On each accepted byte: instr[8*idx +: 8] <= in_data; idx++.
  - On acceptance of byte XLEN/8-1: idx <= 0, go to EXEC.
  - Unaccepted cycles hold all state.
- State EXEC (exactly 1 cycle):
  - core_step=1 (combinational from state); in_ready=0.
  - Register result <= alu_result, out_we <= write_enable, retired <= retired+1 (wraps modulo 2^RETIRE_W).
  - Next state: DRAIN if DRAIN_EN, else LOAD.
- State DRAIN:
  - out_valid=1; out_data = result[8*oidx +: 8].
  - On out_valid && out_ready: oidx++. After byte XLEN/8-1 is consumed: oidx <= 0, go to LOAD.
  - out_ready low stalls indefinitely with out_data stable.
  - in_valid is ignored (in_ready=0).
- instr holds its last assembled value outside LOAD. Bytes overwrite it in place while the next instruction loads; the datapath only acts on core_step.
- Latency:
  - last input byte accepted at cycle N -> core_step at N+1;
  - first out_valid at N+2;
  - earliest next in_ready at N+2+XLEN/8 with out_ready held high.
- With DRAIN_EN=0: in_ready returns at N+2, and out_valid is never asserted.
- busy = (state != LOAD).

Decomposition:
- Shared package core_io_pkg:
  - state enum {LOAD, EXEC, DRAIN};
  - BYTE_W=8 constant;
  - function bytes_per_word(XLEN).
- One natural sub-module: byte_serializer (result register plus output index and valid/ready logic). The LOAD assembler and FSM stay in the top.

Test Plan:
- Load bytes 0x93,0x00,0x50,0x00 with in_valid held high:
  - instr=0x00500093 after the 4th byte; core_step pulses exactly once, on the next cycle;
  - with alu_result driven 0x00000005, bytes 0x05,0x00,0x00,0x00 emerge in order;
  - retired=1.
- Gaps: insert idle cycles between bytes (in_valid low) and hold out_ready low for 3 cycles mid-drain:
  - no core_step until the 4th byte;
  - out_data stays stable during the stall; the byte order is unchanged.
- Drive in_valid=1 throughout EXEC and DRAIN:
  - in_ready=0 and instr is unchanged until the state returns to LOAD.
- Assert rst after 2 bytes loaded, and separately mid-DRAIN:
  - next cycle state=LOAD, idx=0, out_valid=0, retired=0;
  - a fresh 4-byte load then executes correctly.
- DRAIN_EN=0 variant:
  - core_step at N+1, in_ready high at N+2, out_valid never asserted;
  - write_enable=1 during the step gives out_we=1.
- Counter wrap: RETIRE_W=4, run 17 instructions -> retired=1.
